// File: rtl/regfile_sweeper.sv
// Register-file sweeper: dumps every register to a word stream or restores them from one.
// Optional macro REGFILE_SWEEPER_SKIP_ZERO_EN starts sweeps at register 1, skipping the hardwired zero.
module regfile_sweeper #(
  parameter int WORD_SIZE     = 64,
  parameter int REG_ADDR_SIZE = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     mode,
  output logic                     busy,
  output logic                     done,
  output logic                     rf_en,
  output logic [REG_ADDR_SIZE-1:0] rf_write,
  output logic [WORD_SIZE-1:0]     rf_data,
  output logic [REG_ADDR_SIZE-1:0] rf_r1,
  output logic [REG_ADDR_SIZE-1:0] rf_r2,
  input  logic [WORD_SIZE-1:0]     rf_out1,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WORD_SIZE-1:0]     m_data,
  output logic [REG_ADDR_SIZE-1:0] m_addr,
  output logic                     m_last,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WORD_SIZE-1:0]     s_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DUMP    = 2'd1,
    RESTORE = 2'd2,
    DONE    = 2'd3
  } state_t;

`ifdef REGFILE_SWEEPER_SKIP_ZERO_EN
  localparam logic [REG_ADDR_SIZE-1:0] FIRST = REG_ADDR_SIZE'(1);
`else
  localparam logic [REG_ADDR_SIZE-1:0] FIRST = REG_ADDR_SIZE'(0);
`endif
  localparam logic [REG_ADDR_SIZE-1:0] LAST = {REG_ADDR_SIZE{1'b1}};
  localparam logic [REG_ADDR_SIZE-1:0] ONE  = REG_ADDR_SIZE'(1);

  state_t                   state_q, state_d;
  logic [REG_ADDR_SIZE-1:0] addr_q, addr_d;

  // State and address registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= {REG_ADDR_SIZE{1'b0}};
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  // Next-state logic and port drive for the sweep.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    busy     = 1'b0;
    done     = 1'b0;
    rf_en    = 1'b0;
    rf_write = {REG_ADDR_SIZE{1'b0}};
    rf_data  = {WORD_SIZE{1'b0}};
    rf_r1    = {REG_ADDR_SIZE{1'b0}};
    rf_r2    = {REG_ADDR_SIZE{1'b0}};
    m_valid  = 1'b0;
    m_data   = {WORD_SIZE{1'b0}};
    m_addr   = addr_q;
    m_last   = 1'b0;
    s_ready  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = mode ? RESTORE : DUMP;
          addr_d  = FIRST;
        end else begin
          state_d = IDLE;
        end
      end

      DUMP: begin
        busy    = 1'b1;
        rf_r1   = addr_q;
        m_valid = 1'b1;
        m_data  = rf_out1;
        m_last  = (addr_q == LAST);
        if (m_ready) begin
          if (addr_q == LAST) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + ONE;
          end
        end else begin
          addr_d = addr_q;
        end
      end

      RESTORE: begin
        busy     = 1'b1;
        s_ready  = 1'b1;
        rf_write = addr_q;
        rf_data  = s_data;
        // Write strobe follows s_valid directly so the write lands on the handshake edge.
        rf_en    = s_valid;
        if (s_valid) begin
          if (addr_q == LAST) begin
            state_d = DONE;
          end else begin
            addr_d = addr_q + ONE;
          end
        end else begin
          addr_d = addr_q;
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        addr_d  = {REG_ADDR_SIZE{1'b0}};
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_sweeper.sv
// Scoreboard bench for regfile_sweeper: a behavioural register file plus expected-beat queues.
module tb_regfile_sweeper;

  localparam int W = 64;
  localparam int A = 4;
  localparam int NREG = 16;
`ifdef REGFILE_SWEEPER_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int NBEATS = NREG - FIRST;

  typedef struct {
    logic [A-1:0] a;
    logic [W-1:0] d;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         busy, done, rf_en, m_valid, m_last, s_ready;
  logic [A-1:0] rf_write, rf_r1, rf_r2, m_addr;
  logic [W-1:0] rf_data, rf_out1, m_data;
  logic         m_ready = 1'b0;
  logic         s_valid = 1'b0;
  logic [W-1:0] s_data = '0;

  logic [W-1:0] rf_mem [NREG];
  logic [W-1:0] golden [NREG];
  int           wr_count = 0;
  beat_t        q[$];
  int           vectors = 0;
  int           miscompares = 0;

  regfile_sweeper #(.WORD_SIZE(W), .REG_ADDR_SIZE(A)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .busy(busy), .done(done),
    .rf_en(rf_en), .rf_write(rf_write), .rf_data(rf_data),
    .rf_r1(rf_r1), .rf_r2(rf_r2), .rf_out1(rf_out1),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_addr(m_addr), .m_last(m_last),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data)
  );

  always #5 clk = ~clk;

  assign rf_out1 = rf_mem[rf_r1];

  // Behavioural register file write port and write counter.
  always @(posedge clk) begin
    if (rf_en) begin
      rf_mem[rf_write] = rf_data;
      wr_count = wr_count + 1;
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; m_ready = 1'b0; s_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", done); end
    vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    vectors++; if (rf_en !== 1'b0) begin miscompares++; $display("FAIL reset_rf_en got=%b exp=0", rf_en); end
    vectors++; if (m_addr !== 4'd0) begin miscompares++; $display("FAIL reset_m_addr got=%0d exp=0", m_addr); end
    vectors++; if (m_last !== 1'b0) begin miscompares++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    rst_n = 1'b1;
  endtask

  // Starts a sweep; called at posedge+1, returns at posedge+1 with the DUT in the sweep state.
  task automatic kick(input logic md);
    start = 1'b1; mode = md;
    @(posedge clk); #1;
    start = 1'b0; mode = ~md;
  endtask

  task automatic check_done_pulse(input string tag);
    #1;
    vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL %s_done got=%b exp=1", tag, done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL %s_done_busy got=%b exp=0", tag, busy); end
    @(posedge clk); #2;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL %s_done_width got=%b exp=0", tag, done); end
    @(posedge clk); #1;
  endtask

  // stall_mod 0 = ready every cycle; otherwise ready only when cyc%stall_mod == stall_mod-1.
  task automatic test_dump(input int stall_mod, input string tag);
    int wr0;
    q.delete();
    for (int i = FIRST; i < NREG; i++) q.push_back('{a: A'(i), d: golden[i]});
    wr0 = wr_count;
    kick(1'b0);
    for (int cyc = 0; cyc < 400 && q.size() > 0; cyc++) begin
      m_ready = (stall_mod == 0) ? 1'b1 : ((cyc % stall_mod) == stall_mod - 1);
      #1;
      vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid cyc=%0d got=%b exp=1", tag, cyc, m_valid); end
      vectors++; if (m_addr !== q[0].a) begin miscompares++; $display("FAIL %s_addr cyc=%0d got=%0d exp=%0d", tag, cyc, m_addr, q[0].a); end
      vectors++; if (m_data !== q[0].d) begin miscompares++; $display("FAIL %s_data cyc=%0d got=%0d exp=%0d", tag, cyc, m_data, q[0].d); end
      vectors++; if (m_last !== (q[0].a == 4'hF)) begin miscompares++; $display("FAIL %s_last cyc=%0d got=%b exp=%b", tag, cyc, m_last, (q[0].a == 4'hF)); end
      vectors++; if ((rf_en | done) !== 1'b0) begin miscompares++; $display("FAIL %s_quiet cyc=%0d rf_en=%b done=%b exp=0", tag, cyc, rf_en, done); end
      if (m_ready) void'(q.pop_front());
      @(posedge clk); #1;
    end
    m_ready = 1'b0;
    vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL %s_timeout left=%0d exp=0", tag, q.size()); end
    check_done_pulse(tag);
    vectors++; if (wr_count != wr0) begin miscompares++; $display("FAIL %s_no_writes got=%0d exp=%0d", tag, wr_count, wr0); end
  endtask

  task automatic test_restore_gaps();
    int wr0;
    q.delete();
    for (int i = FIRST; i < NREG; i++) begin
      q.push_back('{a: A'(i), d: W'(100 + i)});
      golden[i] = W'(100 + i);
    end
    wr0 = wr_count;
    kick(1'b1);
    for (int cyc = 0; cyc < 400 && q.size() > 0; cyc++) begin
      s_valid = ((cyc % 2) == 0);
      s_data  = s_valid ? q[0].d : W'($urandom);
      #1;
      vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL restore_ready cyc=%0d got=%b exp=1", cyc, s_ready); end
      vectors++; if (rf_en !== s_valid) begin miscompares++; $display("FAIL restore_en cyc=%0d got=%b exp=%b", cyc, rf_en, s_valid); end
      if (s_valid) begin
        vectors++; if (rf_write !== q[0].a) begin miscompares++; $display("FAIL restore_waddr cyc=%0d got=%0d exp=%0d", cyc, rf_write, q[0].a); end
        vectors++; if (rf_data !== q[0].d) begin miscompares++; $display("FAIL restore_wdata cyc=%0d got=%0d exp=%0d", cyc, rf_data, q[0].d); end
        void'(q.pop_front());
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL restore_timeout left=%0d exp=0", q.size()); end
    vectors++; if (wr_count - wr0 != NBEATS) begin miscompares++; $display("FAIL restore_count got=%0d exp=%0d", wr_count - wr0, NBEATS); end
    check_done_pulse("restore");
    for (int i = FIRST; i < NREG; i++) begin
      vectors++; if (rf_mem[i] !== golden[i]) begin miscompares++; $display("FAIL restore_mem[%0d] got=%0d exp=%0d", i, rf_mem[i], golden[i]); end
    end
  endtask

  task automatic test_abort();
    int wr0;
    int beats;
    wr0 = wr_count;
    beats = 0;
    kick(1'b0);
    for (int cyc = 0; cyc < 50 && beats < 5; cyc++) begin
      m_ready = 1'b1;
      start = (cyc == 2); mode = 1'b1;
      #1;
      vectors++; if (m_addr !== A'(FIRST + beats)) begin miscompares++; $display("FAIL abort_addr cyc=%0d got=%0d exp=%0d", cyc, m_addr, FIRST + beats); end
      vectors++; if ((m_valid !== 1'b1) || (s_ready !== 1'b0)) begin miscompares++; $display("FAIL abort_start_ignored cyc=%0d m_valid=%b s_ready=%b exp=1/0", cyc, m_valid, s_ready); end
      beats++;
      @(posedge clk); #1;
    end
    start = 1'b0; m_ready = 1'b1;
    #1;
    vectors++; if (m_addr !== A'(FIRST + 5)) begin miscompares++; $display("FAIL abort_at5 got=%0d exp=%0d", m_addr, FIRST + 5); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_ready = 1'b0;
    #1;
    vectors++; if ((busy | m_valid | done) !== 1'b0) begin miscompares++; $display("FAIL abort_idle busy=%b m_valid=%b done=%b exp=0", busy, m_valid, done); end
    vectors++; if (m_addr !== 4'd0) begin miscompares++; $display("FAIL abort_m_addr got=%0d exp=0", m_addr); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      vectors++; if ((done | busy) !== 1'b0) begin miscompares++; $display("FAIL abort_no_done i=%0d done=%b busy=%b exp=0", i, done, busy); end
    end
    vectors++; if (wr_count != wr0) begin miscompares++; $display("FAIL abort_no_writes got=%0d exp=%0d", wr_count, wr0); end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      rf_mem[i] = W'(3 * i);
      golden[i] = W'(3 * i);
    end
    test_reset();
    @(posedge clk); #1;
    test_dump(0, "dump");
    test_dump(3, "dump_bp");
    test_restore_gaps();
    test_dump(0, "dump_after_restore");
    test_abort();
    test_dump(0, "dump_after_abort");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_sweeper.md
Name: regfile_sweeper

Overview:
- Initiator that drives the register file's write/read port bundle to move the whole register set to or from a word stream.
- Dump mode: reads every register in address order and emits one word per handshake beat.
- Restore mode: accepts one stream word per beat and writes it to successive registers.
- Sits between the register file and the debug/context-switch path; the only agent touching the register file while busy.

Parameters:
- WORD_SIZE, 64, register/stream word width
- REG_ADDR_SIZE, 4, register address width; register count = 2**REG_ADDR_SIZE

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  begin a sweep; sampled only in IDLE
- mode  input  1  0 = dump, 1 = restore; sampled with start
- busy  output  1  high in DUMP or RESTORE
- done  output  1  one-cycle pulse when a sweep completes
- rf_en  output  1  register file write enable
- rf_write  output  REG_ADDR_SIZE  register file write address
- rf_data  output  WORD_SIZE  register file write data
- rf_r1  output  REG_ADDR_SIZE  register file read address 1
- rf_r2  output  REG_ADDR_SIZE  register file read address 2; tied to 0
- rf_out1  input  WORD_SIZE  register file read data 1; combinational from rf_r1
- m_valid  output  1  dump stream valid
- m_ready  input  1  dump stream ready
- m_data  output  WORD_SIZE  dump word
- m_addr  output  REG_ADDR_SIZE  source register of m_data
- m_last  output  1  final dump beat
- s_valid  input  1  restore stream valid
- s_ready  output  1  restore stream ready
- s_data  input  WORD_SIZE  restore word

Behaviour:
- States: IDLE, DUMP, RESTORE, DONE. One address counter `addr`, REG_ADDR_SIZE bits.
- Reset (rst_n low at clock edge):
  - state is IDLE and addr is 0.
  - Outputs: busy=0, done=0, m_valid=0, m_last=0, s_ready=0, rf_en=0.
  - rf_write, rf_r1, rf_r2 are 0. rf_data, m_data and m_addr are don't-care, with m_addr reading 0.
  - Reset mid-sweep aborts immediately; no further rf_en after the reset edge.
- IDLE:
  - start=1 with mode=0 → DUMP; start=1 with mode=1 → RESTORE.
  - addr is loaded with FIRST (0) on that edge.
  - start is ignored in every other state.
- DUMP:
  - rf_r1=addr, m_valid=1, m_data=rf_out1, m_addr=addr.
  - m_last=1 when addr equals all-ones.
  - On m_valid&&m_ready: if m_last → DONE, else addr+1.
  - While m_valid&&!m_ready, rf_r1, m_addr and m_data must hold stable. Data is stable because no write occurs during DUMP.
  - Throughput is one beat per cycle with m_ready held high.
- RESTORE:
  - s_ready=1, rf_write=addr, rf_data=s_data.
  - rf_en=s_valid (combinational), so the write lands on the handshake edge.
  - On s_valid&&s_ready: if addr is all-ones → DONE, else addr+1.
  - No write without a handshake.
- DONE: done=1 for exactly one cycle, busy=0; next state IDLE. A start in DONE is ignored.
- rf_en is 0 in every state other than RESTORE.
- Address never wraps: the terminal beat at the all-ones address always exits to DONE.
- mode is latched into the state at start; later mode changes have no effect.
- Total beats per sweep = 2**REG_ADDR_SIZE (16 by default).

Optional Feature:
- Macro: REGFILE_SWEEPER_SKIP_ZERO_EN.
- Defined: FIRST=1, so register 0 (hardwired zero) is neither dumped nor written. A sweep is 2**REG_ADDR_SIZE−1 beats (15 by default) and m_addr starts at 1.
- Undefined: FIRST=0, full sweep including address 0.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges mid-idle → busy=0, done=0, m_valid=0, s_ready=0, rf_en=0, m_addr=0.
2. Dump, no backpressure: preload reg[i]=3*i, start+mode=0, m_ready=1 → 16 consecutive beats with m_addr 0..15 and m_data 0,3,…,45. m_last only on addr 15; done pulses the cycle after; rf_en stays 0 throughout.
3. Dump with backpressure: m_ready high every third cycle → m_data/m_addr stable while stalled, still exactly 16 accepted beats, values as in scenario 2.
4. Restore with gaps: s_data=100+i, s_valid low every other cycle → exactly 16 rf_en pulses, rf_write 0..15 in order, rf_data 100..115. A subsequent dump returns 100+i for i≥1.
5. Abort/ignore: start asserted during DUMP is ignored. rst_n=0 after beat 5 (addr=5) → IDLE next edge, no done pulse. A new dump then begins at m_addr 0.
6. With REGFILE_SWEEPER_SKIP_ZERO_EN: dump yields 15 beats with m_addr 1..15; restore produces 15 writes with rf_write 1..15 and never addresses 0.
